// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: serialises FRAME_W-bit command words, captures DATA_W-bit read replies.
// All outputs are flops loaded from the next-state view, so they change exactly with the FSM state.
module spi_master_ctrl #(
   parameter int FRAME_W    = 10,
   parameter int DATA_W     = 8,
   parameter int TURNAROUND = 2,
   parameter int GAP        = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [FRAME_W-1:0] cmd_word,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int CNT_W = 8;
   localparam int IDX_W = $clog2(FRAME_W);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      SHIFT,
      WAIT,
      CAPTURE,
      GAP_ST
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FRAME_W-1:0]  cmd_q, cmd_d;
   logic [DATA_W-2:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                ss_n_q, ss_n_d;
   logic                mosi_q, mosi_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rd_valid_q, rd_valid_d;
   logic                is_read_data;

   assign is_read_data = (cmd_q[FRAME_W-1 -: 2] == 2'b11);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         shift_q    <= '0;
         rd_data_q  <= '0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         shift_q    <= shift_d;
         rd_data_q  <= rd_data_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cmd_d   = cmd_word;
               state_d = CMD;
            end
         end
         CMD: begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(FRAME_W - 1);
         end
         SHIFT: begin
            if (cnt_q == '0) begin
               if (is_read_data) begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(TURNAROUND - 1);
               end else begin
                  state_d = GAP_ST;
                  cnt_d   = CNT_W'(GAP - 1);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = CAPTURE;
               cnt_d   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         CAPTURE: begin
            shift_d = {shift_q[DATA_W-3:0], MISO};
            if (cnt_q == '0) begin
               state_d = GAP_ST;
               cnt_d   = CNT_W'(GAP - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP_ST: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output values for the cycle after this edge; the final MISO sample joins the reply directly.
   always_comb begin
      ss_n_d     = 1'b1;
      mosi_d     = 1'b0;
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == GAP_ST) && (state_q != GAP_ST);
      rd_valid_d = (state_d == GAP_ST) && (state_q == CAPTURE);
      rd_data_d  = rd_data_q;
      unique case (state_d)
         CMD: begin
            ss_n_d = 1'b0;
            mosi_d = cmd_d[FRAME_W-1];
         end
         SHIFT: begin
            ss_n_d = 1'b0;
            mosi_d = cmd_q[cnt_d[IDX_W-1:0]];
         end
         WAIT, CAPTURE: begin
            ss_n_d = 1'b0;
         end
         default: begin
            ss_n_d = 1'b1;
         end
      endcase
      if (rd_valid_d) begin
         rd_data_d = {shift_q, MISO};
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign SS_n     = ss_n_q;
   assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl with a frame-level reference model.
module tb_spi_master_ctrl;
   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;
   localparam int TA      = 2;
   localparam int GAPC    = 1;

   logic clk = 1'b0;
   logic rst, start, MISO;
   logic [FRAME_W-1:0] cmd_word;
   logic busy, done, rd_valid, SS_n, MOSI;
   logic [DATA_W-1:0] rd_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_rd_data;
   logic [7:0] ram [256];
   logic [7:0] slv_addr;

   spi_master_ctrl #(.FRAME_W(FRAME_W), .DATA_W(DATA_W), .TURNAROUND(TA), .GAP(GAPC)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd_word(cmd_word),
      .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   // Entry and exit at a negedge with the DUT idle; cycle k is the k-th cycle after the accept edge.
   task automatic run_frame(input logic [9:0] cmd, input logic [7:0] miso_byte,
                            input bit hold, input int glitch_k, input bit use_slave);
      int L;
      bit rd;
      logic [9:0] rx;
      logic [7:0] byte_v;
      logic e_ss, e_mosi, e_done, e_rv, e_busy;
      rd = (cmd[9:8] == 2'b11);
      L = rd ? 20 + TA : 12;
      byte_v = use_slave ? ram[slv_addr] : miso_byte;
      rx = '0;
      start = 1'b1;
      cmd_word = cmd;
      @(posedge clk);
      for (int k = 1; k <= L + GAPC; k++) begin
         @(negedge clk);
         e_ss   = !(k >= 1 && k <= L - 1);
         e_mosi = (k == 1) ? cmd[9] : (k >= 2 && k <= 11) ? cmd[11-k] : 1'b0;
         e_done = (k == L);
         e_rv   = (k == L) && rd;
         e_busy = (k < L + GAPC);
         if (k == L && rd) exp_rd_data = byte_v;
         if (k >= 2 && k <= 11) rx[11-k] = MOSI;
         checks += 6;
         if (SS_n !== e_ss) begin errors++; $display("FAIL ss_n cmd=%h k=%0d got %b exp %b", cmd, k, SS_n, e_ss); end
         if (MOSI !== e_mosi) begin errors++; $display("FAIL mosi cmd=%h k=%0d got %b exp %b", cmd, k, MOSI, e_mosi); end
         if (done !== e_done) begin errors++; $display("FAIL done cmd=%h k=%0d got %b exp %b", cmd, k, done, e_done); end
         if (rd_valid !== e_rv) begin errors++; $display("FAIL rd_valid cmd=%h k=%0d got %b exp %b", cmd, k, rd_valid, e_rv); end
         if (busy !== e_busy) begin errors++; $display("FAIL busy cmd=%h k=%0d got %b exp %b", cmd, k, busy, e_busy); end
         if (rd_data !== exp_rd_data) begin errors++; $display("FAIL rd_data cmd=%h k=%0d got %h exp %h", cmd, k, rd_data, exp_rd_data); end
         if (rd && k >= 12 + TA && k <= 19 + TA)
            MISO = byte_v[7-(k-12-TA)];
         else
            MISO = 1'($urandom);
         if (!hold && k == 1) start = 1'b0;
         if (glitch_k != 0 && k == glitch_k) begin start = 1'b1; cmd_word = ~cmd; end
         if (glitch_k != 0 && k == glitch_k + 1 && !hold) start = 1'b0;
      end
      if (use_slave) begin
         case (rx[9:8])
            2'b00: slv_addr = rx[7:0];
            2'b01: ram[slv_addr] = rx[7:0];
            2'b10: slv_addr = rx[7:0];
            default: ;
         endcase
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      cmd_word = '0;
      MISO = 1'b0;
      exp_rd_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({SS_n, MOSI, busy, done, rd_valid, rd_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got ss=%b mosi=%b busy=%b done=%b rv=%b rd=%h exp 1 0 0 0 0 00",
                     i, SS_n, MOSI, busy, done, rd_valid, rd_data);
         end
      end
   endtask

   task automatic test_write();
      run_frame(10'h0A5, 8'h00, 1'b0, 0, 1'b0);
      run_frame(10'h1FF, 8'h00, 1'b0, 0, 1'b0);
      run_frame(10'h2C3, 8'h00, 1'b0, 0, 1'b0);
   endtask

   task automatic test_read();
      run_frame(10'h300, 8'h3C, 1'b0, 0, 1'b0);
      run_frame(10'h3FF, 8'hA5, 1'b0, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++)
         run_frame(10'($urandom), 8'($urandom), 1'b0, 0, 1'b0);
   endtask

   task automatic test_ignore_start();
      run_frame(10'h0C3, 8'h00, 1'b0, 3, 1'b0);
      run_frame(10'h35A, 8'h96, 1'b0, 5, 1'b0);
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      cmd_word = 10'h0F0;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done k=%0d got done=%b rv=%b exp 0 0", k, done, rd_valid);
         end
         if (k == 7) begin
            exp_rd_data = '0;
            checks++;
            if ({SS_n, MOSI, busy, rd_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
               errors++;
               $display("FAIL reset_mid_vals got ss=%b mosi=%b busy=%b rd=%h exp 1 0 0 00", SS_n, MOSI, busy, rd_data);
            end
         end
         if (k == 1) start = 1'b0;
         if (k == 6) rst = 1'b1;
         if (k == 7) rst = 1'b0;
      end
      run_frame(10'h0A5, 8'h00, 1'b0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_frame(10'h12E, 8'h00, 1'b1, 0, 1'b0);
      run_frame(10'h3A1, 8'h5C, 1'b1, 0, 1'b0);
      run_frame(10'h0FF, 8'h00, 1'b1, 0, 1'b0);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop busy got %b exp 0", busy); end
   endtask

   task automatic test_loopback();
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      slv_addr = 8'h00;
      run_frame(10'h010, 8'h00, 1'b0, 0, 1'b1);
      run_frame(10'h15A, 8'h00, 1'b0, 0, 1'b1);
      run_frame(10'h210, 8'h00, 1'b0, 0, 1'b1);
      run_frame(10'h300, 8'h00, 1'b0, 0, 1'b1);
      checks++;
      if (rd_data !== 8'h5A) begin errors++; $display("FAIL loopback_final rd_data got %h exp 5a", rd_data); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
